// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and encoding rules for the LEGv8 instruction encoder/loader.
// Field layouts are fixed by the LEGv8 R, D, CB and B instruction formats.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    CLS_ADD  = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_AND  = 3'd2,
    CLS_ORR  = 3'd3,
    CLS_LDUR = 3'd4,
    CLS_STUR = 3'd5,
    CLS_CBZ  = 3'd6,
    CLS_B    = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } load_state_e;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic signed [25:0] D_IMM_MIN  = -26'sd256;
  localparam logic signed [25:0] D_IMM_MAX  = 26'sd255;
  localparam logic signed [25:0] CB_IMM_MIN = -26'sd262144;
  localparam logic signed [25:0] CB_IMM_MAX = 26'sd262143;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_t;

  // ok=0 flags an immediate that does not fit the target format's field.
  function automatic enc_t encode(input instr_class_e cls,
                                  input logic [4:0]   rd,
                                  input logic [4:0]   rn,
                                  input logic [4:0]   rm,
                                  input logic [25:0]  imm);
    enc_t                e;
    logic signed [25:0]  s;
    s      = $signed(imm);
    e.ok   = 1'b1;
    e.word = '0;
    case (cls)
      CLS_ADD:  e.word = {OP_ADD, rm, 6'd0, rn, rd};
      CLS_SUB:  e.word = {OP_SUB, rm, 6'd0, rn, rd};
      CLS_AND:  e.word = {OP_AND, rm, 6'd0, rn, rd};
      CLS_ORR:  e.word = {OP_ORR, rm, 6'd0, rn, rd};
      CLS_LDUR: begin
        e.ok   = (s >= D_IMM_MIN) && (s <= D_IMM_MAX);
        e.word = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
      end
      CLS_STUR: begin
        e.ok   = (s >= D_IMM_MIN) && (s <= D_IMM_MAX);
        e.word = {OP_STUR, imm[8:0], 2'b00, rn, rd};
      end
      CLS_CBZ: begin
        e.ok   = (s >= CB_IMM_MIN) && (s <= CB_IMM_MAX);
        e.word = {OP_CBZ, imm[18:0], rd};
      end
      CLS_B:    e.word = {OP_B, imm};
      default:  e.ok = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_sync_fifo.sv
// Synchronous FIFO with pointer-wrap-bit full/empty detection.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes LEGv8 field tuples into machine words, buffers them and writes
// them to instruction memory at consecutive word addresses.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 64,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              err_range,
  output logic [15:0]       words_written
);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              err_q, err_d;
  enc_t              enc;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_rdata;

  assign enc      = encode(instr_class_e'(in_class), in_rd, in_rn, in_rm, in_imm);
  assign in_ready = (state_q == ST_LOAD) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc.ok;
  assign imem_we  = !fifo_empty;
  assign pop      = imem_we && imem_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i (enc.word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A restart clears the counters; it can only occur with the FIFO empty.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    err_d   = err_q;
    if (pop) begin
      addr_d = addr_q + ADDR_W'(4);
      if (words_q != '1) words_d = words_q + 16'd1;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = BASE_ADDR;
          words_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept && !enc.ok) err_d = 1'b1;
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr     = addr_q;
  assign imem_wdata    = fifo_empty ? '0 : fifo_rdata;
  assign load_done     = (state_q == ST_DONE);
  assign err_range     = err_q;
  assign words_written = words_q;

endmodule
